// File: rtl/cordic_engine.sv
// Iterative radix-2 CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// with quadrant pre-rotation so the full +/-pi range converges. Outputs carry the CORDIC gain.
module cordic_engine #(
    parameter int WIDTH = 30,
    parameter int FRAC  = 27,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic signed [WIDTH-1:0] in_z,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z
);

    localparam int CW = 5;
    localparam real HALF_PI_R = 1.5707963267948966 * (2.0 ** FRAC);
    localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(longint'(HALF_PI_R));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // atan(2^-idx) held in Q2.30, rounded half-up down to FRAC fraction bits
    function automatic logic signed [WIDTH-1:0] atan_entry(input logic [CW-1:0] idx);
        logic [63:0] q30;
        logic [63:0] rnd;
        int          sh;
        case (idx)
            5'd0:    q30 = 64'd843314857;
            5'd1:    q30 = 64'd497837829;
            5'd2:    q30 = 64'd263043837;
            5'd3:    q30 = 64'd133525159;
            5'd4:    q30 = 64'd67021687;
            5'd5:    q30 = 64'd33543516;
            5'd6:    q30 = 64'd16775851;
            5'd7:    q30 = 64'd8388437;
            5'd8:    q30 = 64'd4194283;
            5'd9:    q30 = 64'd2097149;
            5'd10:   q30 = 64'd1048576;
            5'd11:   q30 = 64'd524288;
            5'd12:   q30 = 64'd262144;
            5'd13:   q30 = 64'd131072;
            5'd14:   q30 = 64'd65536;
            5'd15:   q30 = 64'd32768;
            5'd16:   q30 = 64'd16384;
            5'd17:   q30 = 64'd8192;
            5'd18:   q30 = 64'd4096;
            5'd19:   q30 = 64'd2048;
            5'd20:   q30 = 64'd1024;
            5'd21:   q30 = 64'd512;
            5'd22:   q30 = 64'd256;
            5'd23:   q30 = 64'd128;
            default: q30 = 64'd0;
        endcase
        sh = 30 - FRAC;
        if (sh > 0) begin
            rnd = (q30 + (64'd1 << (sh - 1))) >> sh;
        end else begin
            rnd = q30;
        end
        return WIDTH'(rnd);
    endfunction

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           iter_q, iter_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic signed [WIDTH-1:0] xs_s, ys_s, ang_s, xn_s, yn_s, zn_s;
    logic                    load_s, last_s, dir_pos_s;

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            out_z_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            out_z_q <= out_z_d;
        end
    end

    // Next-state logic; start only matters outside RUN
    always_comb begin
        load_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_s  = (iter_q == CW'(ITER - 1));
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_d = S_DONE;
                else        state_d = S_RUN;
            end
            S_DONE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags follow the state being entered so they are registered
    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Operand load with quadrant pre-rotation, micro-rotation, and result capture
    always_comb begin
        xs_s      = x_q >>> iter_q;
        ys_s      = y_q >>> iter_q;
        ang_s     = atan_entry(iter_q);
        dir_pos_s = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
        if (dir_pos_s) begin
            xn_s = x_q - ys_s;
            yn_s = y_q + xs_s;
            zn_s = z_q - ang_s;
        end else begin
            xn_s = x_q + ys_s;
            yn_s = y_q - xs_s;
            zn_s = z_q + ang_s;
        end

        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mode_d  = mode_q;
        iter_d  = iter_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_z_d = out_z_q;

        if (load_s) begin
            mode_d = mode;
            iter_d = '0;
            x_d    = in_x;
            y_d    = in_y;
            z_d    = in_z;
            if (!mode) begin
                if (in_z > HALF_PI) begin
                    x_d = -in_y;
                    y_d = in_x;
                    z_d = in_z - HALF_PI;
                end else if (in_z < -HALF_PI) begin
                    x_d = in_y;
                    y_d = -in_x;
                    z_d = in_z + HALF_PI;
                end else begin
                    x_d = in_x;
                end
            end else begin
                if (in_x[WIDTH-1] && !in_y[WIDTH-1]) begin
                    x_d = in_y;
                    y_d = -in_x;
                    z_d = in_z + HALF_PI;
                end else if (in_x[WIDTH-1] && in_y[WIDTH-1]) begin
                    x_d = -in_y;
                    y_d = in_x;
                    z_d = in_z - HALF_PI;
                end else begin
                    x_d = in_x;
                end
            end
        end else if (state_q == S_RUN) begin
            x_d    = xn_s;
            y_d    = yn_s;
            z_d    = zn_s;
            iter_d = iter_q + 5'd1;
            if (last_s) begin
                out_x_d = xn_s;
                out_y_d = yn_s;
                out_z_d = zn_s;
            end else begin
                out_x_d = out_x_q;
            end
        end else begin
            iter_d = iter_q;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out_x = out_x_q;
    assign out_y = out_y_q;
    assign out_z = out_z_q;

endmodule

// File: doc/cordic_engine.md
CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 30, meaning datapath width in bits, two's complement.
REQ-002 The block SHALL have parameter FRAC, default 27, meaning the number of fraction bits of every data/angle port (legal range ITER <= FRAC <= WIDTH-3).
REQ-003 The block SHALL have parameter ITER, default 16, meaning the number of micro-rotations per operation (legal range 4..24).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: launches one operation when sampled high in IDLE or DONE.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = rotation, 1 = vectoring; sampled with start.
REQ-008 The block SHALL have ports in_x, in_y, in_z, input, WIDTH bits each, signed: operands sampled with start; in_z is an angle in radians.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-011 The block SHALL have ports out_x, out_y, out_z, output, WIDTH bits each, signed registered results, held until the next done.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE: IDLE/DONE + start -> RUN; RUN -> DONE after ITER iterations; DONE -> IDLE if start is low.
REQ-013 start SHALL be ignored while in RUN, with no effect on state or datapath.
REQ-014 Latency SHALL be fixed: start is sampled at edge 0, iterations i = 0..ITER-1 occur at edges 1..ITER, and done = 1 with valid outputs during cycle ITER+1.
REQ-015 start sampled high in DONE SHALL launch the next operation back-to-back, giving a throughput of one result per ITER+1 cycles.
REQ-016 At the start edge the block SHALL load the internal x/y/z registers with quadrant pre-rotation.
REQ-017 In rotation mode, if in_z > pi/2 the load SHALL be (x, y, z) = (-in_y, in_x, in_z - pi/2).
REQ-018 In rotation mode, if in_z < -pi/2 the load SHALL be (x, y, z) = (in_y, -in_x, in_z + pi/2); otherwise the operands SHALL load unchanged.
REQ-019 In vectoring mode, if in_x < 0 and in_y >= 0 the load SHALL be (x, y, z) = (in_y, -in_x, in_z + pi/2).
REQ-020 In vectoring mode, if in_x < 0 and in_y < 0 the load SHALL be (x, y, z) = (-in_y, in_x, in_z - pi/2); otherwise the operands SHALL load unchanged.
REQ-021 Each iteration i SHALL compute x' = x - d*(y >>> i), y' = y + d*(x >>> i), z' = z - d*atan(2^-i), all in WIDTH-bit wrap-around arithmetic using arithmetic shifts.
REQ-022 In rotation mode d SHALL be +1 if z >= 0, else -1.
REQ-023 In vectoring mode d SHALL be +1 if y < 0, else -1.
REQ-024 The angle table SHALL hold atan(2^-i) for i = 0..23 as Q2.30 constants, each reduced to FRAC bits by round-half-up right shift of (30-FRAC).
REQ-025 pi/2 SHALL be round(pi/2 * 2^FRAC) at the given FRAC.
REQ-026 Outputs SHALL carry the uncompensated CORDIC gain An ~= 1.646760; the caller pre-scales by K = 0.607253 where unit gain is needed.
REQ-027 Rotation results SHALL be out_x ~= An*(x0 cos z0 - y0 sin z0) and out_y ~= An*(y0 cos z0 + x0 sin z0) from the original operands, with out_z ~= 0.
REQ-028 Vectoring results SHALL be out_x ~= An*sqrt(x0^2 + y0^2), out_y ~= 0 and out_z ~= z0 + atan2(y0, x0).
REQ-029 Accuracy: every result SHALL be within 2^(FRAC-ITER+2) LSB of the ideal value for |inputs| <= 1.0 and |in_z| <= pi.
REQ-030 out_x, out_y and out_z SHALL update only at the edge entering DONE and SHALL remain stable in IDLE and RUN.
REQ-031 Input changes SHALL have no effect except at a start-sampling edge.

Reset
REQ-032 While reset = 0 at a rising clk edge, the block SHALL enter IDLE with busy = 0, done = 0, out_x = out_y = out_z = 0, iteration counter = 0 and internal x/y/z = 0.
REQ-033 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first edge.
REQ-034 If start and reset are both active at the same edge, reset SHALL win.

Verification
REQ-035 Rotation test: defaults, mode 0, in_x = 81503902 (K), in_y = 0, in_z = 0 -> done exactly 17 cycles after start; out_x = 134217728 +/-8192 and out_y = 0 +/-8192.
REQ-036 Quadrant test: mode 0, in_x = K, in_y = 0, in_z = 421657428 (pi) -> out_x = -134217728 +/-8192 and out_y = 0 +/-8192, exercising pre-rotation.
REQ-037 Vectoring test: mode 1, in_x = in_y = 134217728, in_z = 0 -> out_z = 105414357 (pi/4) +/-8192 and out_x = 312576000 +/-8192.
REQ-038 Vectoring quadrant test: mode 1, in_x = -134217728, in_y = 0 -> out_z = +/-421657428 +/-8192 and out_y = 0 +/-8192.
REQ-039 Handshake test: start held high continuously -> a done pulse every 17 cycles, pulses while busy ignored, and busy low only in DONE cycles.
REQ-040 Reset test: reset = 0 at iteration 8 -> next cycle busy = 0, outputs = 0, no done; a fresh start then completes normally.
